// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Per-register countdown scoreboard for the ID stage. It replaces fixed
// EXE/MEM destination comparators with one counter per architectural register.
// Each counter holds the number of cycles until that register's result can be
// read by ID. An instruction whose valid sources have a nonzero counter stalls.
//
// Parameters
//   ADDR_W   register address width (NUM_REGS = 2**ADDR_W)
//   MAX_LAT  largest countdown value (>= 1); lat_ID above it is clamped
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   id_valid         ID holds a real instruction
//   src1_ID/src2_ID  source registers
//   is_imm           src2 replaced by an immediate ...
//   ST_or_BNE        ... unless a store/branch still reads src2
//   dest_ID          destination register
//   WB_EN_ID         instruction writes dest_ID
//   lat_ID           cycles until the result is readable (0 = no hazard)
//   flush            squash every outstanding write
//   hazard_detected  stall ID (combinational)
//   pending          bit r set while counter r is nonzero
//   stall_count      stalled-cycle counter (only when built with
//                    HAZARD_STALL_COUNT_EN defined)
//
// Optional feature macro: HAZARD_STALL_COUNT_EN
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int ADDR_W  = 5,
  parameter int MAX_LAT = 2,
  localparam int NUM_REGS = 2 ** ADDR_W,
  localparam int CNT_W    = $clog2(MAX_LAT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [ADDR_W-1:0]   src1_ID,
  input  logic [ADDR_W-1:0]   src2_ID,
  input  logic                is_imm,
  input  logic                ST_or_BNE,
  input  logic [ADDR_W-1:0]   dest_ID,
  input  logic                WB_EN_ID,
  input  logic [CNT_W-1:0]    lat_ID,
  input  logic                flush,
  output logic                hazard_detected,
  output logic [NUM_REGS-1:0] pending
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [31:0]         stall_count
`endif
);

  localparam logic [CNT_W-1:0] MAX_LAT_C = CNT_W'(MAX_LAT);

  // Register 0 is never written, so it has no storage at all.
  logic [CNT_W-1:0] cnt [1:NUM_REGS-1];

  logic             src2_valid;
  logic             issue;
  logic [CNT_W-1:0] lat_clamped;

  // Saturating decrement: a counter at zero stays at zero.
  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] c);
    return (c != '0) ? c - CNT_W'(1) : '0;
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational decision (uses pre-issue state, so an instruction whose
  // source equals its own destination never stalls on itself).
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    pending = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      pending[r] = (cnt[r] != '0);
    end
  end

  assign src2_valid      = ~is_imm | ST_or_BNE;
  assign hazard_detected = id_valid &
                           (pending[src1_ID] | (src2_valid & pending[src2_ID]));
  // Flush does not mask the hazard output, but it does cancel the issue.
  assign issue           = id_valid & ~hazard_detected & ~flush;
  assign lat_clamped     = (lat_ID > MAX_LAT_C) ? MAX_LAT_C : lat_ID;

  // ---------------------------------------------------------------------------
  // Counter update
  // ---------------------------------------------------------------------------
  // NOTE: the counter array is reset (not left to power-up values) because an
  // asynchronous reset must drop every outstanding hazard immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // counter samples the same pre-edge values regardless of loop order.
        if (flush) begin
          cnt[r] <= '0;
        end else if (issue && WB_EN_ID && (dest_ID == ADDR_W'(r))) begin
          // WAW: a younger, shorter write never shortens an older one.
          cnt[r] <= (dec_sat(cnt[r]) > lat_clamped) ? dec_sat(cnt[r])
                                                    : lat_clamped;
        end else begin
          cnt[r] <= dec_sat(cnt[r]);
        end
      end
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  // Counts stalled ID cycles; wraps naturally, untouched by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (id_valid && hazard_detected) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule
